qdr_bist_master: RTL and testbench
==================================

# qdr_bist_master

Synthesizable traffic initiator that drives the user side of the QDR controller: `usr_rd_strb`, `usr_wr_strb`, `usr_addr`, `usr_wr_data` out; `usr_rd_data` and `usr_rd_dvld` in. On a start pulse it writes a deterministic pattern over addresses 0..`addr_last`, then reads the same range back. It checks each returned word in order against a regenerated expected value and reports pass/fail and an error count. It sits in the clk0 domain beside the controller and is used for board bring-up and soak testing of each QDR chip.

## Interface
- `DATA_WIDTH`, 36, QDR data bus width; user words are 2*DATA_WIDTH.
- `ADDR_WIDTH`, 21, QDR burst address width.
- `DRAIN_TIMEOUT`, 32, cycles allowed after the last read strobe plus read latency before declaring timeout.
- `clk0` input 1: sole clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `phy_rdy` input 1: controller calibrated; gates start and aborts an active run when it falls.
- `start` input 1: single-cycle run request.
- `addr_last` input ADDR_WIDTH: last address tested; sampled at start.
- `seed` input DATA_WIDTH: pattern seed; sampled at start.
- `usr_wr_strb` output 1: write command.
- `usr_rd_strb` output 1: read command.
- `usr_addr` output ADDR_WIDTH: command address.
- `usr_wr_data` output 2*DATA_WIDTH: write word.
- `usr_rd_data` input 2*DATA_WIDTH: returned read word.
- `usr_rd_dvld` input 1: read word valid; arrives in command order.
- `busy` output 1: run in progress.
- `done` output 1: run finished; held until the next accepted start.
- `pass` output 1: valid with `done`.
- `timeout` output 1: drain timeout occurred.
- `aborted` output 1: `phy_rdy` fell during the run.
- `err_cnt` output 16: mismatched words, saturating at 0xFFFF.
- `err_addr` output ADDR_WIDTH: first failing address.
- `err_data` output 2*DATA_WIDTH: first failing word.

## Operation
- Pattern: `f(a)` = `a` replicated and truncated to DATA_WIDTH bits, XOR `seed_q`. Word(a) = {~f(a), f(a)}.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE: if `start && phy_rdy`, latch `addr_last`/`seed`, clear `err_cnt`, `timeout`, `aborted`, capture registers and the wr/rd/expected counters, then go to WRITE. `start` without `phy_rdy`, or `start` in any other state, is ignored.
- WRITE: one `usr_wr_strb` per cycle, `usr_addr` = wr_cnt, `usr_wr_data` = Word(wr_cnt). When wr_cnt == addr_last_q, go to READ.
- READ: one `usr_rd_strb` per cycle, `usr_addr` = rd_cnt. When rd_cnt == addr_last_q, go to DRAIN and load the drain timer with 10 + DRAIN_TIMEOUT.
- Checker runs in every state. On each `usr_rd_dvld`, compare `usr_rd_data` with Word(exp_cnt), then increment exp_cnt. A mismatch increments `err_cnt`. A `usr_rd_dvld` after all N = addr_last_q+1 words have been received also counts as an error; its expected word is don't-care.
- DRAIN: go to DONE when exp_cnt == N. If the timer reaches 0 first, set `timeout` and go to DONE.
- `phy_rdy` low in WRITE, READ or DRAIN: set `aborted` and go to DONE next cycle, with no further strobes.
- `pass` = `err_cnt` == 0 && !`timeout` && !`aborted`, registered on entry to DONE.
- Width rule: counters are ADDR_WIDTH+1 bits, so `addr_last` = all ones (N = 2^ADDR_WIDTH) terminates correctly without wrap.
- Strobes are never both high in the same cycle. Outside WRITE/READ, strobes are 0 and `usr_addr`/`usr_wr_data` hold 0.

## Timing
- Reset value of every output is 0; FSM resets to IDLE.
- `reset` mid-run clears outputs immediately and asynchronously; no strobe follows.
- All outputs are registered.
- Start sampled at cycle 0 → first `usr_wr_strb` at cycle 1.
- Writes occupy cycles 1..N; reads occupy cycles N+1..2N.
- The controller returns `usr_rd_dvld` 10 cycles after each strobe, so the last dvld arrives at cycle 2N+10. `done`, `pass` and `busy`=0 are asserted at cycle 2N+11.
- `busy` is high from cycle 1 until DONE is entered.
- No backpressure: the controller accepts one command per cycle.

## Configuration
- `QDR_BIST_ERR_CAPTURE_EN` defined: on the first mismatch of a run, latch `err_addr` = exp_cnt and `err_data` = `usr_rd_data`. Both hold until the next accepted start.
- Not defined: the capture registers are not built and `err_addr`/`err_data` are tied to 0. Counting and pass/fail are unchanged.

## Test plan
- Loopback memory model (10-cycle latency), addr_last=3, seed=0 → write strobes at addresses 0..3 on cycles 1-4, reads on cycles 5-8, `done`=1 and `pass`=1 at cycle 19, `err_cnt`=0.
- Same setup, model flips bit 0 of the word for address 2 → `err_cnt`=1, `pass`=0; with the macro, `err_addr`=2 and `err_data` = Word(2)^1.
- Model withholds the last dvld → `timeout`=1 after 42 cycles in DRAIN, `pass`=0, `done`=1.
- `start` with `phy_rdy`=0 → no strobes, `busy`=0. Then start with `phy_rdy`=1 and drop `phy_rdy` during WRITE → `aborted`=1, `pass`=0, no strobes after the drop.
- `reset` pulse during READ → all outputs 0 asynchronously. A new start with addr_last=0 gives one write, one read and `pass`=1 at cycle 13.
- Model emits one extra dvld after a clean run → `err_cnt`=1, `pass`=0.

Source files
------------

// File: rtl/qdr_bist_master.sv
// qdr_bist_master: write/read-back pattern BIST initiator for the QDR user interface (clk0 domain).
// Define QDR_BIST_ERR_CAPTURE_EN to build the first-error capture registers (err_addr/err_data).
module qdr_bist_master #(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 21,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic                    clk0,
  input  logic                    reset,
  input  logic                    phy_rdy,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr_last,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    usr_wr_strb,
  output logic                    usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic                    aborted,
  output logic [15:0]             err_cnt,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [2*DATA_WIDTH-1:0] err_data
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int REP = (DATA_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;
  localparam int TW  = $clog2(DRAIN_TIMEOUT + 11);
  localparam logic [TW-1:0] T_LOAD = TW'(DRAIN_TIMEOUT + 10);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_last_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [CW-1:0]         wr_cnt, rd_cnt, exp_cnt;
  logic [TW-1:0]         timer;

  function automatic logic [2*DATA_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] s);
    logic [REP*ADDR_WIDTH-1:0] rep;
    logic [DATA_WIDTH-1:0]     f;
    rep = {REP{a}};
    f   = rep[DATA_WIDTH-1:0] ^ s;
    return {~f, f};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [CW-1:0] last_cnt, n_words, exp_cnt_nxt, wr_nxt, rd_nxt;
  logic [15:0]   err_cnt_nxt;
  logic          extra_word, mismatch, all_rcvd, start_acc, run_abort;

  // Counters are one bit wider than the address so N = 2^ADDR_WIDTH is representable.
  assign last_cnt    = {1'b0, addr_last_q};
  assign n_words     = last_cnt + CW'(1);
  assign wr_nxt      = wr_cnt + CW'(1);
  assign rd_nxt      = rd_cnt + CW'(1);
  assign extra_word  = (exp_cnt >= n_words);
  assign mismatch    = usr_rd_dvld &&
                       (extra_word || (usr_rd_data != word_of(exp_cnt[ADDR_WIDTH-1:0], seed_q)));
  assign exp_cnt_nxt = (usr_rd_dvld && !extra_word) ? exp_cnt + CW'(1) : exp_cnt;
  assign err_cnt_nxt = mismatch ? sat_inc16(err_cnt) : err_cnt;
  assign all_rcvd    = (exp_cnt_nxt == n_words);
  assign start_acc   = start && phy_rdy && (state == S_IDLE || state == S_DONE);
  assign run_abort   = !phy_rdy && (state == S_WRITE || state == S_READ || state == S_DRAIN);

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_last_q <= '0;
      seed_q      <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      exp_cnt     <= '0;
      timer       <= '0;
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;
      usr_addr    <= '0;
      usr_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      exp_cnt     <= exp_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;
      usr_addr    <= '0;
      usr_wr_data <= '0;
      if (run_abort) begin
        state   <= S_DONE;
        aborted <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            // pass keeps tracking late stray words while done is shown
            if (state == S_DONE) pass <= (err_cnt_nxt == 16'd0) && !timeout && !aborted;
            if (start_acc) begin
              state       <= S_WRITE;
              addr_last_q <= addr_last;
              seed_q      <= seed;
              wr_cnt      <= '0;
              rd_cnt      <= '0;
              exp_cnt     <= '0;
              err_cnt     <= '0;
              timeout     <= 1'b0;
              aborted     <= 1'b0;
              busy        <= 1'b1;
              done        <= 1'b0;
              pass        <= 1'b0;
              usr_wr_strb <= 1'b1;
              usr_wr_data <= word_of('0, seed);
            end
          end
          S_WRITE: begin
            if (wr_cnt == last_cnt) begin
              state       <= S_READ;
              usr_rd_strb <= 1'b1;
            end else begin
              wr_cnt      <= wr_nxt;
              usr_wr_strb <= 1'b1;
              usr_addr    <= wr_nxt[ADDR_WIDTH-1:0];
              usr_wr_data <= word_of(wr_nxt[ADDR_WIDTH-1:0], seed_q);
            end
          end
          S_READ: begin
            if (rd_cnt == last_cnt) begin
              state <= S_DRAIN;
              timer <= T_LOAD;
            end else begin
              rd_cnt      <= rd_nxt;
              usr_rd_strb <= 1'b1;
              usr_addr    <= rd_nxt[ADDR_WIDTH-1:0];
            end
          end
          S_DRAIN: begin
            if (all_rcvd) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt_nxt == 16'd0);
            end else if (timer == TW'(1)) begin
              state   <= S_DONE;
              timeout <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef QDR_BIST_ERR_CAPTURE_EN
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      err_addr <= '0;
      err_data <= '0;
    end else if (start_acc) begin
      err_addr <= '0;
      err_data <= '0;
    end else if (mismatch && err_cnt == 16'd0) begin
      err_addr <= exp_cnt[ADDR_WIDTH-1:0];
      err_data <= usr_rd_data;
    end
  end
`else
  assign err_addr = '0;
  assign err_data = '0;
`endif

endmodule

// File: tb/tb_qdr_bist_master.sv
// Scoreboard bench for qdr_bist_master: 10-cycle loopback memory model plus per-scenario checks.
module tb_qdr_bist_master;
  localparam int DW = 36;
  localparam int AW = 21;

  logic          clk0 = 1'b0;
  logic          reset = 1'b1;
  logic          phy_rdy = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_last = '0;
  logic [DW-1:0] seed = '0;
  logic          usr_wr_strb, usr_rd_strb;
  logic [AW-1:0] usr_addr;
  logic [2*DW-1:0] usr_wr_data;
  logic [2*DW-1:0] usr_rd_data = '0;
  logic          usr_rd_dvld = 1'b0;
  logic          busy, done, pass, timeout, aborted;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr;
  logic [2*DW-1:0] err_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [2*DW-1:0] data;
    int            cyc;
  } cmd_t;
  typedef struct {
    bit            v;
    logic [2*DW-1:0] d;
  } rsp_t;

  cmd_t exp_q[$];
  rsp_t rq[$];
  logic [2*DW-1:0] mem [int];
  int flip_addr = -1;
  int drop_addr = -1;
  bit inject_extra = 1'b0;

  qdr_bist_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DRAIN_TIMEOUT(32)) dut (
    .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy), .start(start),
    .addr_last(addr_last), .seed(seed),
    .usr_wr_strb(usr_wr_strb), .usr_rd_strb(usr_rd_strb), .usr_addr(usr_addr),
    .usr_wr_data(usr_wr_data), .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .aborted(aborted),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_data(err_data)
  );

  always #5 clk0 = ~clk0;
  initial forever @(posedge clk0) cyc = cyc + 1;

  function automatic logic [2*DW-1:0] exp_word(input int a, input logic [DW-1:0] s);
    logic [AW-1:0] av;
    logic [DW-1:0] f;
    av = AW'(a);
    for (int i = 0; i < DW; i++) f[i] = av[i % AW] ^ s[i];
    return {~f, f};
  endfunction

  // Loopback memory: read data returns exactly 10 cycles after its strobe.
  initial begin : mem_model
    rsp_t ent, out;
    forever begin
      @(negedge clk0);
      if (reset) begin
        rq.delete();
        usr_rd_dvld = 1'b0;
        usr_rd_data = '0;
      end else begin
        if (usr_wr_strb) mem[int'(usr_addr)] = usr_wr_data;
        ent.v = usr_rd_strb && (int'(usr_addr) != drop_addr);
        ent.d = mem.exists(int'(usr_addr)) ? mem[int'(usr_addr)] : '0;
        if (usr_rd_strb && int'(usr_addr) == flip_addr) ent.d[0] = ~ent.d[0];
        rq.push_back(ent);
        out.v = 1'b0;
        out.d = '0;
        if (rq.size() > 10) out = rq.pop_front();
        if (!out.v && inject_extra) begin
          out.v = 1'b1;
          out.d = '1;
          inject_extra = 1'b0;
        end
        usr_rd_dvld = out.v;
        usr_rd_data = out.v ? out.d : '0;
      end
    end
  end

  // Command scoreboard: every strobe must match the next expected command.
  initial begin : cmd_monitor
    cmd_t e;
    forever begin
      @(negedge clk0);
      if (usr_wr_strb || usr_rd_strb) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe cycle=%0d wr=%0b rd=%0b addr=%0d", cyc - base,
                   usr_wr_strb, usr_rd_strb, usr_addr);
        end else begin
          e = exp_q.pop_front();
          if ({usr_wr_strb, usr_rd_strb} !== {e.wr, !e.wr} || usr_addr !== e.addr ||
              usr_wr_data !== e.data || (cyc - base) != e.cyc) begin
            failures++;
            $display("FAIL cmd got wr=%0b rd=%0b addr=%0d data=%0h cycle=%0d required wr=%0b addr=%0d data=%0h cycle=%0d",
                     usr_wr_strb, usr_rd_strb, usr_addr, usr_wr_data, cyc - base,
                     e.wr, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] al, input logic [DW-1:0] sd,
                           input int n_wr, input int n_rd);
    int n;
    n = int'(al) + 1;
    for (int i = 0; i < n_wr; i++)
      exp_q.push_back('{wr: 1'b1, addr: AW'(i), data: exp_word(i, sd), cyc: i + 1});
    for (int i = 0; i < n_rd; i++)
      exp_q.push_back('{wr: 1'b0, addr: AW'(i), data: '0, cyc: n + i + 1});
    @(negedge clk0);
    addr_last = al;
    seed = sd;
    start = 1'b1;
    base = cyc;
    @(negedge clk0);
    start = 1'b0;
    addr_last = '1;
    seed = DW'($urandom());
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk0);
      if (done) begin
        dc = cyc - base;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk0);
    checks++;
    if ({usr_wr_strb, usr_rd_strb, usr_addr, usr_wr_data, busy, done, pass, timeout, aborted,
         err_cnt, err_addr, err_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got nonzero busy=%0b done=%0b err_cnt=%0d required all 0", busy, done, err_cnt);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk0);
    checks++;
    if ({busy, done, usr_wr_strb, usr_rd_strb} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_loopback();
    int dc;
    start_run(3, '0, 4, 4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_cycle1 got %0b required 1", busy);
    end
    wait_done(60, dc);
    checks++;
    if (dc != 19) begin
      failures++;
      $display("FAIL loop_done_cycle got %0d required 19", dc);
    end
    checks++;
    if ({pass, timeout, aborted, busy, err_cnt} !== {4'b1000, 16'd0}) begin
      failures++;
      $display("FAIL loop_status got pass=%0b to=%0b ab=%0b busy=%0b err=%0d required 1 0 0 0 0",
               pass, timeout, aborted, busy, err_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL loop_cmds_left got %0d required 0", exp_q.size());
    end
    start_run(5, 36'h9_A5A5_1234, 6, 6);
    wait_done(60, dc);
    checks++;
    if (dc != 23 || pass !== 1'b1 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL loop_seed got cycle=%0d pass=%0b err=%0d required 23 1 0", dc, pass, err_cnt);
    end
  endtask

  task automatic test_bitflip();
    int dc;
    flip_addr = 2;
    start_run(3, '0, 4, 4);
    wait_done(60, dc);
    flip_addr = -1;
    checks++;
    if (dc != 19 || err_cnt !== 16'd1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL bitflip got cycle=%0d err=%0d pass=%0b required 19 1 0", dc, err_cnt, pass);
    end
    checks++;
`ifdef QDR_BIST_ERR_CAPTURE_EN
    if (err_addr !== AW'(2) || err_data !== (exp_word(2, '0) ^ 72'd1)) begin
      failures++;
      $display("FAIL capture got addr=%0d data=%0h required 2 %0h", err_addr, err_data,
               exp_word(2, '0) ^ 72'd1);
    end
`else
    if (err_addr !== '0 || err_data !== '0) begin
      failures++;
      $display("FAIL capture_off got addr=%0d data=%0h required 0 0", err_addr, err_data);
    end
`endif
  endtask

  task automatic test_timeout();
    int dc;
    drop_addr = 3;
    start_run(3, '0, 4, 4);
    wait_done(100, dc);
    drop_addr = -1;
    checks++;
    if (dc != 51) begin
      failures++;
      $display("FAIL timeout_cycle got %0d required 51", dc);
    end
    checks++;
    if ({done, timeout, pass, aborted, err_cnt} !== {4'b1100, 16'd0}) begin
      failures++;
      $display("FAIL timeout_status got done=%0b to=%0b pass=%0b ab=%0b err=%0d required 1 1 0 0 0",
               done, timeout, pass, aborted, err_cnt);
    end
  endtask

  task automatic test_phy_rdy();
    int dc;
    @(negedge clk0);
    phy_rdy = 1'b0;
    start = 1'b1;
    @(negedge clk0);
    start = 1'b0;
    repeat (4) @(negedge clk0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL start_no_phy got busy=%0b done=%0b required 0 1", busy, done);
    end
    phy_rdy = 1'b1;
    start_run(7, 36'h1_2345_6789, 3, 0);
    repeat (2) @(negedge clk0);
    phy_rdy = 1'b0;
    wait_done(20, dc);
    repeat (5) @(negedge clk0);
    phy_rdy = 1'b1;
    checks++;
    if (dc != 4 || aborted !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort got cycle=%0d ab=%0b pass=%0b busy=%0b required 4 1 0 0", dc, aborted, pass, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_cmds_left got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int dc;
    start_run(3, 36'h5_5555_AAAA, 4, 2);
    repeat (5) @(negedge clk0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({usr_wr_strb, usr_rd_strb, usr_addr, usr_wr_data, busy, done, pass, timeout, aborted,
         err_cnt, err_addr, err_data} !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%0b rd=%0b addr=%0d required all 0", busy, usr_rd_strb, usr_addr);
    end
    @(negedge clk0);
    #2 reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_cmds_left got %0d required 0", exp_q.size());
    end
    start_run(0, 36'h0_0F0F_F0F0, 1, 1);
    wait_done(40, dc);
    checks++;
    if (dc != 13 || pass !== 1'b1 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL single_word got cycle=%0d pass=%0b err=%0d required 13 1 0", dc, pass, err_cnt);
    end
  endtask

  task automatic test_extra_dvld();
    int dc;
    start_run(3, 36'hF_0000_000F, 4, 4);
    wait_done(60, dc);
    checks++;
    if (dc != 19 || pass !== 1'b1) begin
      failures++;
      $display("FAIL pre_extra got cycle=%0d pass=%0b required 19 1", dc, pass);
    end
    inject_extra = 1'b1;
    repeat (3) @(negedge clk0);
    checks++;
    if (err_cnt !== 16'd1 || pass !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL extra_dvld got err=%0d pass=%0b done=%0b required 1 0 1", err_cnt, pass, done);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_loopback();
    test_bitflip();
    test_timeout();
    test_phy_rdy();
    test_reset_midrun();
    test_extra_dvld();
    repeat (3) @(negedge clk0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
